// File: rtl/nco_pkg.sv
// Shared constants, loader state encoding and the detune saturation helper for the NCO.
package nco_pkg;
   localparam int NOTE_W    = 7;
   localparam int STEP_W    = 16;
   localparam int ACC_W_DEF = 16;
   localparam int DETUNE_W  = 8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOOKUP,
      S_CAPTURE
   } load_state_t;

   // Two guard bits hold both the sign and the overflow past 16 bits.
   function automatic logic [STEP_W-1:0] sat_step(input logic [STEP_W-1:0]   step,
                                                 input logic [DETUNE_W-1:0] detune);
      logic signed [STEP_W+1:0] sum;
      sum = $signed({2'b00, step})
          + $signed({{(STEP_W+2-DETUNE_W){detune[DETUNE_W-1]}}, detune});
      if (sum < 0)
         return '0;
      else if (sum > $signed({2'b00, {STEP_W{1'b1}}}))
         return '1;
      else
         return sum[STEP_W-1:0];
   endfunction
endpackage

// File: rtl/nco_step_loader.sv
// Note handshake, step_size_rom lookup FSM and step register.
// With NCO_DETUNE_EN defined, a saturated detuned step is registered alongside step_q.
module nco_step_loader
   import nco_pkg::*;
(
   input  logic              CLK,
   input  logic              RST,
   input  logic              CE,
   input  logic              NOTE_VALID,
   input  logic [NOTE_W-1:0] NOTE,
   output logic              NOTE_READY,
   output logic              ROM_CE,
   output logic [NOTE_W-1:0] ROM_A,
   input  logic [STEP_W-1:0] ROM_D,
`ifdef NCO_DETUNE_EN
   input  logic [DETUNE_W-1:0] DETUNE,
`endif
   output logic [STEP_W-1:0] step_eff
);
   load_state_t       state;
   logic [NOTE_W-1:0] note_q;
   logic [STEP_W-1:0] step_q;
   logic              rom_en_q;
   logic              ready_q;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= S_IDLE;
         note_q   <= '0;
         step_q   <= '0;
         rom_en_q <= 1'b0;
         ready_q  <= 1'b1;
      end else if (CE) begin
         rom_en_q <= 1'b0;
         ready_q  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (NOTE_VALID) begin
                  note_q   <= NOTE;
                  rom_en_q <= 1'b1;
                  state    <= S_LOOKUP;
               end else begin
                  ready_q <= 1'b1;
               end
            end
            S_LOOKUP:  state <= S_CAPTURE;
            S_CAPTURE: begin
               step_q  <= ROM_D;
               ready_q <= 1'b1;
               state   <= S_IDLE;
            end
            default: begin
               ready_q <= 1'b1;
               state   <= S_IDLE;
            end
         endcase
      end
   end

   // The ROM shares CE, so gating its enable keeps ROM_D stable through a stall.
   assign ROM_CE     = rom_en_q & CE;
   assign ROM_A      = note_q;
   assign NOTE_READY = ready_q;

`ifdef NCO_DETUNE_EN
   logic [STEP_W-1:0] eff_q;

   always_ff @(posedge CLK) begin
      if (RST)
         eff_q <= '0;
      else if (CE && state == S_CAPTURE)
         eff_q <= sat_step(ROM_D, DETUNE);
   end

   assign step_eff = eff_q;
`else
   assign step_eff = step_q;
`endif
endmodule

// File: rtl/nco_phase_acc.sv
// NCO phase accumulator: loads a step per MIDI note and advances the phase on each sample tick.
// Optional feature macro: NCO_DETUNE_EN adds the signed DETUNE fine offset.
module nco_phase_acc
   import nco_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              CE,
   input  logic              SAMPLE_TICK,
   input  logic              GATE,
   input  logic              NOTE_VALID,
   input  logic [NOTE_W-1:0] NOTE,
   output logic              NOTE_READY,
   output logic              ROM_CE,
   output logic [NOTE_W-1:0] ROM_A,
   input  logic [STEP_W-1:0] ROM_D,
`ifdef NCO_DETUNE_EN
   input  logic [DETUNE_W-1:0] DETUNE,
`endif
   output logic [ACC_W-1:0]  PHASE,
   output logic              PHASE_VALID,
   output logic              WRAP
);
   logic [STEP_W-1:0] step_eff;
   logic [ACC_W:0]    sum;

   nco_step_loader u_loader (
      .CLK        (CLK),
      .RST        (RST),
      .CE         (CE),
      .NOTE_VALID (NOTE_VALID),
      .NOTE       (NOTE),
      .NOTE_READY (NOTE_READY),
      .ROM_CE     (ROM_CE),
      .ROM_A      (ROM_A),
      .ROM_D      (ROM_D),
`ifdef NCO_DETUNE_EN
      .DETUNE     (DETUNE),
`endif
      .step_eff   (step_eff)
   );

   // One extra bit captures the carry-out that becomes WRAP.
   assign sum = {1'b0, PHASE} + {{(ACC_W + 1 - STEP_W){1'b0}}, step_eff};

   always_ff @(posedge CLK) begin
      if (RST) begin
         PHASE       <= '0;
         WRAP        <= 1'b0;
         PHASE_VALID <= 1'b0;
      end else if (CE) begin
         if (SAMPLE_TICK) begin
            PHASE_VALID <= 1'b1;
            if (GATE) begin
               {WRAP, PHASE} <= sum;
            end else begin
               PHASE <= '0;
               WRAP  <= 1'b0;
            end
         end else begin
            WRAP        <= 1'b0;
            PHASE_VALID <= 1'b0;
         end
      end
   end
endmodule

// File: doc/nco_phase_acc.md
# nco_phase_acc

Phase accumulator core of the NCO, directly downstream of `step_size_rom`. It accepts a 7-bit MIDI note over a valid/ready handshake. It drives `step_size_rom` to fetch the 16-bit step size for that note, latches the step, and advances a phase accumulator once per sample tick. The phase word and a wrap pulse feed the waveform generators.

## Interface
- `ACC_W`, default 16: phase accumulator width (≥16); step is zero-extended to `ACC_W`.
- `CLK` in 1: sole clock; all logic on rising edge.
- `RST` in 1: synchronous, active-high reset.
- `CE` in 1: global clock enable; low freezes all state.
- `SAMPLE_TICK` in 1: one-cycle strobe at sample rate.
- `GATE` in 1: high runs the oscillator; low holds phase at 0.
- `NOTE_VALID` in 1: note request.
- `NOTE` in 7: MIDI note number.
- `NOTE_READY` out 1: loader idle, can accept a note.
- `ROM_CE` out 1: enable to `step_size_rom`.
- `ROM_A` out 7: address to `step_size_rom`.
- `ROM_D` in 16: step size from `step_size_rom`; 1-cycle registered latency.
- `DETUNE` in 8: signed fine offset. Present only with `NCO_DETUNE_EN`.
- `PHASE` out ACC_W: accumulator value.
- `PHASE_VALID` out 1: one-cycle pulse when `PHASE` updates.
- `WRAP` out 1: one-cycle pulse on accumulator carry-out.

## Operation
- **Loader FSM** has three states: IDLE → LOOKUP → CAPTURE → IDLE.
  - IDLE: `NOTE_READY`=1. An edge with `CE & NOTE_VALID` latches `NOTE` into `note_q` and moves to LOOKUP.
  - LOOKUP: `ROM_CE`=1 and `ROM_A`=`note_q`. Next state is CAPTURE.
  - CAPTURE: `ROM_D` is valid. `step_q <= ROM_D`, then IDLE.
  - `NOTE_READY`=0 in LOOKUP and CAPTURE. Notes presented then are not accepted; the source holds them.
- `ROM_CE`=0 and `ROM_A`=`note_q` outside LOOKUP.
- **Effective step**: `step_eff = step_q`, or the detuned value when configured (see Configuration).
- **Accumulator**, evaluated on an edge with `CE & SAMPLE_TICK`:
  - `GATE`=1: `PHASE <= (PHASE + step_eff) mod 2^ACC_W`. `WRAP` is set to the carry-out and `PHASE_VALID` is set to 1.
  - `GATE`=0: `PHASE <= 0`, `WRAP` is 0 and `PHASE_VALID` is 1.
  - No tick: `WRAP` and `PHASE_VALID` are 0 and `PHASE` holds.
- A note change does not reset phase, so frequency changes are phase-continuous.
- **Reset values**: FSM IDLE; `note_q`=0; `step_q`=0; `PHASE`=0; `WRAP`=0; `PHASE_VALID`=0; `ROM_CE`=0; `ROM_A`=0. `NOTE_READY` reads 1 on the first cycle after reset deasserts.

## Timing
- Note accepted at edge n. LOOKUP runs in cycle n..n+1, CAPTURE in n+1..n+2, and `step_q` updates at edge n+2.
- The first tick that uses the new step is one sampled at edge n+3 or later.
- A tick coinciding with the CAPTURE edge (n+2) uses the old `step_q`.
- `NOTE_READY` returns to 1 in the cycle after edge n+2. Back-to-back notes are therefore accepted every 3 cycles at most.
- `PHASE`, `WRAP` and `PHASE_VALID` are registered. They are valid the cycle after the tick edge; `WRAP` and `PHASE_VALID` are single-cycle pulses.
- `CE` low stalls the FSM mid-lookup:
  - `ROM_CE` is forced to 0.
  - State and registers hold.
  - The lookup resumes when `CE` returns. The ROM uses the same CE, so `ROM_D` is preserved.
- `RST` mid-lookup aborts the lookup: FSM goes to IDLE, `step_q`=0, and the note is discarded.
- `RST` has priority over every other input.

## Configuration
- `NCO_DETUNE_EN` defined:
  - The `DETUNE` port exists.
  - `step_eff = clamp(step_q + sign_ext(DETUNE), 0, 65535)`.
  - `step_eff` is computed in 18 bits and then saturated.
  - `step_eff` is registered at edge n+2, together with `step_q`.
  - `DETUNE` changes take effect at the next CAPTURE edge only.
- `NCO_DETUNE_EN` undefined:
  - No `DETUNE` port.
  - `step_eff = step_q`.
  - No adder is present.

## Structure
- Shared package `nco_pkg`:
  - `NOTE_W`=7, `STEP_W`=16, `ACC_W_DEF`=16.
  - Loader state enum (`S_IDLE`, `S_LOOKUP`, `S_CAPTURE`).
  - Detune width constant `DETUNE_W`=8.
- Sub-module `nco_step_loader` contains:
  - The handshake.
  - The FSM.
  - The ROM drive.
  - The `step_q` register, plus the detune saturation when enabled.
- `nco_phase_acc` contains the accumulator and instantiates `nco_step_loader`.
- `step_size_rom` stays external and is wired by the parent.

## Test plan
- Reset then note 69, `GATE`=1: `ROM_A`=69 in LOOKUP and `step_q`=901.
  - After 1 tick, `PHASE`=901.
  - The 73rd tick gives `WRAP`=1 and `PHASE`=237; ticks 1–72 give `WRAP`=0.
- Note 127, ticks continuous: `step_q`=25690. The 3rd tick wraps with `PHASE`=11534.
- Tick on the CAPTURE edge while switching note 0 (step 17) to note 60 (step 536):
  - That tick adds 17.
  - The next tick adds 536.
  - `NOTE_VALID` held across LOOKUP/CAPTURE sees `NOTE_READY`=0 and is not accepted until IDLE.
- `GATE` low with ticks: `PHASE`=0, `PHASE_VALID` pulses and `WRAP` stays 0. On gate rise, the first tick gives `PHASE`=`step_q`.
- `RST` during LOOKUP, then ticks with `GATE`=1: `step_q`=0, `PHASE` stays 0 and `NOTE_READY`=1.
  - `CE` low for 5 cycles mid-CAPTURE: all state holds and the lookup completes with the correct step.
- `NCO_DETUNE_EN`:
  - Note 0 with `DETUNE`=-20 gives `step_eff`=0 (clamped) and `PHASE` stays 0.
  - Note 127 with `DETUNE`=+127 gives `step_eff`=25817.
